// File: rtl/fir_mac_sched_pkg.sv
// fir_sched_pkg: shared types and helpers for the FIR MAC scheduler.
//   fir_sched_state_t : scheduler FSM state, also exported on the debug port
//   idx_w             : index width for an N-entry space (never below 1)
//   ptr_inc / ptr_sub : modular pointer arithmetic for TAPS-deep rings that
//                       need not be a power of two
package fir_sched_pkg;

  typedef enum logic [2:0] {
    ARB    = 3'd0,
    LOAD   = 3'd1,
    MAC    = 3'd2,
    DRAIN  = 3'd3,
    COMMIT = 3'd4
  } fir_sched_state_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // (a + 1) mod m, for a < m
  function automatic int unsigned ptr_inc(input int unsigned a, input int unsigned m);
    return (a + 1 == m) ? 0 : a + 1;
  endfunction

  // (a - b) mod m, for a < m and b <= m
  function automatic int unsigned ptr_sub(input int unsigned a, input int unsigned b,
                                          input int unsigned m);
    return (a >= b) ? a - b : a + m - b;
  endfunction

endpackage

// File: rtl/fir_mac_sched_if.sv
// fir_mac_sched_if: FIFO strobes and MAC/sample-RAM control bus of the
// FIR MAC scheduler.
//   master : the scheduler (drives pops, pushes, RAM write and MAC controls)
//   slave  : the FIFOs / sample RAM / MAC datapath side
//
// Handshake semantics:
//   in_empty/in_rd_en  : first-word fall-through FIFO. A pop happens on every
//                        rising edge where in_rd_en[c]=1; in_rd_en[c] is only
//                        raised while in_empty[c]=0.
//   out_full/out_wr_en : a push happens on every rising edge where
//                        out_wr_en[c]=1; out_wr_en[c] is only raised while
//                        out_full[c]=0.
//   smp_wr_en, mac_valid : single-cycle strobes with no back-pressure; the
//                        RAM and MAC accept one operation per cycle.
interface fir_mac_sched_if #(
  parameter int unsigned NCH  = 2,
  parameter int unsigned TAPS = 32
) ();
  import fir_sched_pkg::*;

  localparam int unsigned CH_W   = idx_w(NCH);
  localparam int unsigned ADDR_W = idx_w(TAPS);

  logic [NCH-1:0]    in_empty;
  logic [NCH-1:0]    in_rd_en;
  logic [NCH-1:0]    out_full;
  logic [NCH-1:0]    out_wr_en;
  logic              smp_wr_en;
  logic [CH_W-1:0]   smp_wr_ch;
  logic [ADDR_W-1:0] smp_wr_addr;
  logic              mac_valid;
  logic              mac_first;
  logic [CH_W-1:0]   mac_ch;
  logic [ADDR_W-1:0] mac_smp_addr;
  logic [ADDR_W-1:0] mac_coef_addr;

  modport master (
    input  in_empty, out_full,
    output in_rd_en, out_wr_en, smp_wr_en, smp_wr_ch, smp_wr_addr,
           mac_valid, mac_first, mac_ch, mac_smp_addr, mac_coef_addr
  );

  modport slave (
    output in_empty, out_full,
    input  in_rd_en, out_wr_en, smp_wr_en, smp_wr_ch, smp_wr_addr,
           mac_valid, mac_first, mac_ch, mac_smp_addr, mac_coef_addr
  );

endinterface

// File: rtl/fir_mac_sched_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin arbiter.
//   req         in  NCH   request vector
//   last_grant  in  CH_W  index granted most recently; search starts one above
//   grant_oh    out NCH   one-hot grant (all zero when nothing requests)
//   grant_idx   out CH_W  index of the granted requester
//   grant_valid out 1     some requester was granted
module rr_arbiter
  import fir_sched_pkg::*;
#(
  parameter  int unsigned NCH  = 2,
  localparam int unsigned CH_W = idx_w(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [CH_W-1:0] last_grant,
  output logic [NCH-1:0]  grant_oh,
  output logic [CH_W-1:0] grant_idx,
  output logic            grant_valid
);

  int unsigned cand;

  // Walk last_grant+1, last_grant+2, ... wrapping at NCH; last_grant itself
  // is visited last, so a lone requester can still be re-granted.
  always_comb begin
    grant_oh    = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = 0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      cand = (32'(last_grant) + i) % NCH;
      if (!grant_valid && req[CH_W'(cand)]) begin
        grant_valid            = 1'b1;
        grant_idx              = CH_W'(cand);
        grant_oh[CH_W'(cand)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fir_mac_sched.sv
// fir_mac_sched: shares one FIR multiply-accumulate datapath between NCH
// decimating channels. Samples are moved from each channel's input FIFO
// into a per-channel circular sample RAM; after DECIMATION new samples a
// TAPS-long MAC burst is issued (newest sample first) and, once the MAC
// pipeline has drained, the accumulator is pushed into that channel's
// output FIFO. Control only: no sample or coefficient data passes here.
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   bus        master modport of fir_mac_sched_if (FIFO strobes, sample
//              RAM write port, MAC controls)
//   state_dbg  out  current scheduler state
module fir_mac_sched
  import fir_sched_pkg::*;
#(
  parameter int unsigned NCH        = 2,
  parameter int unsigned TAPS       = 32,
  parameter int unsigned DECIMATION = 2,
  parameter int unsigned MAC_LAT    = 2
) (
  input  logic             clk,
  input  logic             rst,
  fir_mac_sched_if.master  bus,
  output fir_sched_state_t state_dbg
);

  localparam int unsigned CH_W   = idx_w(NCH);
  localparam int unsigned ADDR_W = idx_w(TAPS);
  localparam int unsigned DEC_W  = idx_w(DECIMATION);
  localparam int unsigned LAT_W  = idx_w(MAC_LAT);

  fir_sched_state_t  state;
  logic [CH_W-1:0]   g;           // channel owning LOAD/MAC/DRAIN/COMMIT
  logic [CH_W-1:0]   last_grant;  // updated only on a completed commit
  logic [ADDR_W-1:0] k;           // MAC tap index
  logic [LAT_W-1:0]  lat;         // DRAIN cycle count
  logic [ADDR_W-1:0] head [NCH];  // next write slot per channel
  logic [DEC_W-1:0]  dec  [NCH];  // samples of the current batch so far

  logic [NCH-1:0]  req;
  logic [NCH-1:0]  grant_oh;
  logic [CH_W-1:0] grant_idx;
  logic            grant_valid;

  assign req       = ~bus.in_empty;
  assign state_dbg = state;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req         (req),
    .last_grant  (last_grant),
    .grant_oh    (grant_oh),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB;
      g          <= '0;
      last_grant <= CH_W'(NCH - 1);
      k          <= '0;
      lat        <= '0;
      for (int c = 0; c < NCH; c++) begin
        head[c] <= '0;
        dec[c]  <= '0;
      end
    end else begin
      case (state)
        ARB: begin
          if (grant_valid) begin
            g     <= grant_idx;
            state <= LOAD;
          end
        end
        LOAD: begin
          // An empty FIFO mid-batch parks the channel: head/dec are kept so
          // the batch resumes on its next grant.
          if (bus.in_empty[g]) begin
            state <= ARB;
          end else begin
            head[g] <= ADDR_W'(ptr_inc(32'(head[g]), TAPS));
            if (dec[g] == DEC_W'(DECIMATION - 1)) begin
              dec[g] <= '0;
              k      <= '0;
              state  <= MAC;
            end else begin
              dec[g] <= dec[g] + 1'b1;
            end
          end
        end
        MAC: begin
          k <= k + 1'b1;
          if (k == ADDR_W'(TAPS - 1)) begin
            lat   <= '0;
            state <= (MAC_LAT > 0) ? DRAIN : COMMIT;
          end
        end
        DRAIN: begin
          if (lat == LAT_W'(MAC_LAT - 1)) begin
            state <= COMMIT;
          end else begin
            lat <= lat + 1'b1;
          end
        end
        COMMIT: begin
          // A full output FIFO holds the whole scheduler here on purpose:
          // back-pressure reaches every channel.
          if (!bus.out_full[g]) begin
            last_grant <= g;
            state      <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  // Outputs are decoded from registered state; only the FIFO strobes also
  // look at the live empty/full flags so a sample can be popped per cycle.
  // Everything is forced low while rst is high.
  always_comb begin
    bus.in_rd_en      = '0;
    bus.out_wr_en     = '0;
    bus.smp_wr_en     = 1'b0;
    bus.smp_wr_ch     = '0;
    bus.smp_wr_addr   = '0;
    bus.mac_valid     = 1'b0;
    bus.mac_first     = 1'b0;
    bus.mac_ch        = '0;
    bus.mac_smp_addr  = '0;
    bus.mac_coef_addr = '0;
    if (!rst) begin
      case (state)
        LOAD: begin
          if (!bus.in_empty[g]) begin
            bus.in_rd_en[g] = 1'b1;
            bus.smp_wr_en   = 1'b1;
            bus.smp_wr_ch   = g;
            bus.smp_wr_addr = head[g];
          end
        end
        MAC: begin
          bus.mac_valid     = 1'b1;
          bus.mac_first     = (k == '0);
          bus.mac_ch        = g;
          // head[g] points one past the newest sample.
          bus.mac_smp_addr  = ADDR_W'(ptr_sub(32'(head[g]), 32'(k) + 1, TAPS));
          bus.mac_coef_addr = k;
        end
        DRAIN: begin
          bus.mac_ch = g;
        end
        COMMIT: begin
          bus.mac_ch = g;
          if (!bus.out_full[g]) begin
            bus.out_wr_en[g] = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sched.sv
// Self-checking bench for fir_mac_sched (NCH=2, TAPS=4, DECIMATION=2,
// MAC_LAT=2). Input FIFOs are modelled as push/pop counters; a negedge
// monitor predicts every sample-RAM write slot, every MAC beat and every
// output commit from the reads it observes.
module tb_fir_mac_sched;
  import fir_sched_pkg::*;

  localparam int unsigned NCH        = 2;
  localparam int unsigned TAPS       = 4;
  localparam int unsigned DECIMATION = 2;
  localparam int unsigned MAC_LAT    = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_mac_sched_if #(.NCH(NCH), .TAPS(TAPS)) bus ();
  fir_sched_state_t state_dbg;

  fir_mac_sched #(
    .NCH        (NCH),
    .TAPS       (TAPS),
    .DECIMATION (DECIMATION),
    .MAC_LAT    (MAC_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- input FIFO model ----------------
  int pushed [NCH];
  int popped [NCH] = '{default: 0};
  logic [NCH-1:0] emp;

  always_comb begin
    emp = '0;
    for (int c = 0; c < NCH; c++) emp[c] = (pushed[c] == popped[c]);
  end
  assign bus.in_empty = emp;

  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++)
      if (bus.in_rd_en[c]) popped[c] <= popped[c] + 1;
  end

  // ---------------- scoreboard state ----------------
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int check_cnt = 0;
  logic [31:0] exp_q[$];     // expected MAC beats
  int commit_q[$];           // expected commit channels
  int commit_log[$];         // observed commit channels
  int commit_cnt = 0;
  int reads [NCH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Decimal packing keeps beat mismatches readable: ch,first,smp,coef.
  function automatic logic [31:0] beat(input int ch, input int first, input int smp,
                                       input int coef);
    return 32'(ch * 1000 + first * 100 + smp * 10 + coef);
  endfunction

  function automatic logic [31:0] outs();
    return 32'({bus.in_rd_en, bus.out_wr_en, bus.smp_wr_en, bus.smp_wr_ch,
                bus.smp_wr_addr, bus.mac_valid, bus.mac_first, bus.mac_ch,
                bus.mac_smp_addr, bus.mac_coef_addr});
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    for (int c = 0; c < NCH; c++) reads[c] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        commit_q.delete();
        for (int c = 0; c < NCH; c++) reads[c] = 0;
      end else begin
        check("rd_onehot", 32'($countones(bus.in_rd_en) <= 1), 32'd1);
        check("wr_onehot", 32'($countones(bus.out_wr_en) <= 1), 32'd1);
        check("smp_wr_en_match", 32'(bus.smp_wr_en), 32'(bus.in_rd_en != '0));
        for (int c = 0; c < NCH; c++) begin
          if (bus.in_rd_en[c]) begin
            check("smp_wr_ch", 32'(bus.smp_wr_ch), 32'(c));
            check("smp_wr_addr", 32'(bus.smp_wr_addr), 32'(reads[c] % TAPS));
            reads[c]++;
            if (reads[c] % DECIMATION == 0) begin
              for (int k = 0; k < TAPS; k++)
                exp_q.push_back(beat(c, (k == 0) ? 1 : 0,
                                     ((reads[c] - 1 - k) % TAPS + TAPS) % TAPS, k));
              commit_q.push_back(c);
            end
          end
        end
        if (bus.mac_valid) begin
          check("mac_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0)
            check("mac_beat", beat(int'(bus.mac_ch), int'(bus.mac_first),
                                   int'(bus.mac_smp_addr), int'(bus.mac_coef_addr)),
                  exp_q.pop_front());
        end
        for (int c = 0; c < NCH; c++) begin
          if (bus.out_wr_en[c]) begin
            check("commit_expected", 32'(commit_q.size() > 0), 32'd1);
            check("burst_done_before_commit", 32'(exp_q.size()), 32'd0);
            if (commit_q.size() > 0) check("commit_ch", 32'(c), 32'(commit_q.pop_front()));
            commit_log.push_back(c);
            commit_cnt++;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input int c, input int n);
    @(posedge clk);
    #1;
    pushed[c] = pushed[c] + n;
  endtask

  task automatic wait_commits(input int target, input int budget);
    int n;
    n = 0;
    while (commit_cnt < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("commit_timeout", 32'(commit_cnt >= target), 32'd1);
  endtask

  task automatic reset_hold();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs_zero", outs(), 32'd0);
    check("reset_state", 32'(state_dbg), 32'(ARB));
  endtask

  function automatic fir_sched_state_t t1_state(input int n);
    if (n == 1 || n == 2) return LOAD;
    if (n >= 3 && n <= 6) return MAC;
    if (n == 7 || n == 8) return DRAIN;
    if (n == 9) return COMMIT;
    return ARB;
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish before 100us");
    $fatal(1, "bench timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    int n;
    logic [1:0] t1_smp [4];
    t1_smp = '{2'd1, 2'd0, 2'd3, 2'd2};
    for (int c = 0; c < NCH; c++) pushed[c] = 0;
    bus.out_full = '0;

    // Test 1: single channel, two samples; exact cycle timeline.
    reset_hold();
    pushed[0] = 2;
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 12; i++) begin
      check("t1_state", 32'(state_dbg), 32'(t1_state(i)));
      check("t1_rd", 32'(bus.in_rd_en), (i == 1 || i == 2) ? 32'd1 : 32'd0);
      check("t1_mac_valid", 32'(bus.mac_valid), 32'(i >= 3 && i <= 6));
      check("t1_mac_first", 32'(bus.mac_first), 32'(i == 3));
      if (i >= 3 && i <= 6) begin
        check("t1_smp_addr", 32'(bus.mac_smp_addr), 32'(t1_smp[i - 3]));
        check("t1_coef_addr", 32'(bus.mac_coef_addr), 32'(i - 3));
      end
      check("t1_wr", 32'(bus.out_wr_en), (i == 9) ? 32'd1 : 32'd0);
      @(negedge clk);
      #1;
    end

    // Test 2: both channels busy from reset -> 0,1,0,1.
    reset_hold();
    pushed[0] = pushed[0] + 4;
    pushed[1] = pushed[1] + 4;
    @(negedge clk);
    rst = 1'b0;
    base = commit_cnt;
    wait_commits(base + 4, 200);
    if (commit_log.size() >= base + 4) begin
      check("t2_order0", 32'(commit_log[base]), 32'd0);
      check("t2_order1", 32'(commit_log[base + 1]), 32'd1);
      check("t2_order2", 32'(commit_log[base + 2]), 32'd0);
      check("t2_order3", 32'(commit_log[base + 3]), 32'd1);
    end

    // Test 3: channel 0 runs dry mid-batch; channel 1 served; ch0 resumes
    // and its head wraps past TAPS-1.
    reset_hold();
    pushed[0] = pushed[0] + 1;
    pushed[1] = pushed[1] + 2;
    @(negedge clk);
    rst = 1'b0;
    base = commit_cnt;
    wait_commits(base + 1, 60);
    check("t3_first_commit_ch1", 32'(commit_log[commit_log.size() - 1]), 32'd1);
    check("t3_ch0_partial_reads", 32'(reads[0]), 32'd1);
    push(0, 1);
    wait_commits(base + 2, 60);
    check("t3_resume_ch0", 32'(commit_log[commit_log.size() - 1]), 32'd0);
    check("t3_ch0_reads_after_resume", 32'(reads[0]), 32'd2);
    push(0, 2);
    wait_commits(base + 3, 60);
    push(0, 1);
    repeat (10) @(negedge clk);
    #1;
    check("t3_partial_no_commit", 32'(commit_cnt), 32'(base + 3));
    check("t3_partial_state", 32'(state_dbg), 32'(ARB));
    push(0, 1);
    wait_commits(base + 4, 60);
    check("t3_ch0_reads_total", 32'(reads[0]), 32'd6);

    // Test 4: out_full[1] blocks COMMIT and starves channel 0.
    @(posedge clk);
    #1;
    bus.out_full = 2'b10;
    pushed[1] = pushed[1] + 2;
    push(0, 2);
    base = commit_cnt;
    n = 0;
    while (state_dbg != COMMIT && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t4_reach_commit", 32'(state_dbg), 32'(COMMIT));
    for (int i = 0; i < 20; i++) begin
      check("t4_hold_state", 32'(state_dbg), 32'(COMMIT));
      check("t4_hold_wr", 32'(bus.out_wr_en), 32'd0);
      check("t4_hold_rd", 32'(bus.in_rd_en), 32'd0);
      check("t4_hold_mac_ch", 32'(bus.mac_ch), 32'd1);
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    bus.out_full = 2'b00;
    @(negedge clk);
    #1;
    check("t4_release_wr", 32'(bus.out_wr_en), 32'd2);
    wait_commits(base + 2, 60);
    check("t4_single_ch1_write", 32'(commit_log[base]), 32'd1);
    check("t4_then_ch0", 32'(commit_log[base + 1]), 32'd0);

    // Test 5: reset during the MAC burst at k=2.
    push(1, 2);
    base = commit_cnt;
    n = 0;
    while (!(bus.mac_valid && bus.mac_coef_addr == 2'd2) && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t5_reach_k2", 32'(bus.mac_valid && bus.mac_coef_addr == 2'd2), 32'd1);
    rst = 1'b1;
    #1;
    check("t5_outs_during_rst", outs(), 32'd0);
    push(0, 2);
    pushed[1] = pushed[1] + 2;
    @(negedge clk);
    #1;
    check("t5_outs_after_rst", outs(), 32'd0);
    check("t5_state_after_rst", 32'(state_dbg), 32'(ARB));
    rst = 1'b0;
    n = 0;
    while (bus.in_rd_en == '0 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t5_first_grant_ch0", 32'(bus.in_rd_en), 32'd1);
    wait_commits(base + 2, 80);
    repeat (20) @(negedge clk);
    #1;
    check("t5_no_aborted_commit", 32'(commit_cnt), 32'(base + 2));
    if (commit_log.size() >= base + 2) begin
      check("t5_order0", 32'(commit_log[base]), 32'd0);
      check("t5_order1", 32'(commit_log[base + 1]), 32'd1);
    end

    check("final_mac_q_empty", 32'(exp_q.size()), 32'd0);
    check("final_commit_q_empty", 32'(commit_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
